// File: rtl/spi_pkg.sv
// Shared types and helpers for the system-clocked SPI shift engine.
package spi_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Mode numbers are {cpol, cpha}
    localparam logic [1:0] SPI_MODE0 = 2'b00;
    localparam logic [1:0] SPI_MODE1 = 2'b01;
    localparam logic [1:0] SPI_MODE2 = 2'b10;
    localparam logic [1:0] SPI_MODE3 = 2'b11;

    // A zero or oversize request means a full-width frame.
    function automatic int unsigned eff_len(input int unsigned frame_len,
                                            input int unsigned data_width);
        return (frame_len == 0 || frame_len > data_width) ? data_width : frame_len;
    endfunction

endpackage

// File: rtl/spi_edge_sel.sv
// Maps raw SCK edge strobes onto sample/drive strobes for the latched CPOL/CPHA.
module spi_edge_sel (
    input  logic sck_rise,
    input  logic sck_fall,
    input  logic cpol,
    input  logic cpha,
    output logic sample_stb,
    output logic drive_stb
);

    logic rise, fall, lead, trail;

    // A cycle carrying both strobes is ambiguous and is dropped entirely.
    assign rise  = sck_rise & ~sck_fall;
    assign fall  = sck_fall & ~sck_rise;
    assign lead  = cpol ? fall : rise;
    assign trail = cpol ? rise : fall;

    assign sample_stb = cpha ? trail : lead;
    assign drive_stb  = cpha ? lead  : trail;

endmodule

// File: rtl/spi_shift_engine.sv
// Full-duplex SPI shifter running on the system clock, driven by SCK edge strobes.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter  int DATA_WIDTH = 8,
    localparam int LEN_W      = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  clk_in,
    input  logic                  rstn_in,
    input  logic                  spe_in,
    input  logic                  cpol_in,
    input  logic                  cpha_in,
    input  logic                  lsbfe_in,
    input  logic [LEN_W-1:0]      frame_len_in,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] tx_data_in,
    input  logic                  sck_rise_in,
    input  logic                  sck_fall_in,
    input  logic                  serial_in,
    output logic                  serial_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [DATA_WIDTH-1:0] rx_data_out
);

    localparam int IDX_W = $clog2(DATA_WIDTH);

    state_t                state, state_n;
    logic                  cpol_q, cpha_q, lsbfe_q;
    logic                  cpol_n, cpha_n, lsbfe_n;
    logic [LEN_W-1:0]      len_q, len_n;
    logic [DATA_WIDTH-1:0] tx_q, tx_n;
    logic [LEN_W-1:0]      tx_cnt, tx_cnt_n, rx_cnt, rx_cnt_n;
    logic [DATA_WIDTH-1:0] rx_shadow, rx_shadow_n, rx_data_n;
    logic                  serial_n, done_n;
    logic                  sample_stb, drive_stb;

    function automatic logic [IDX_W-1:0] bit_idx(input logic             lsb,
                                                 input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] k);
        logic [LEN_W-1:0] r;
        r = lsb ? k : len - LEN_W'(1) - k;
        return r[IDX_W-1:0];
    endfunction

    spi_edge_sel u_edge_sel (
        .sck_rise   (sck_rise_in),
        .sck_fall   (sck_fall_in),
        .cpol       (cpol_q),
        .cpha       (cpha_q),
        .sample_stb (sample_stb),
        .drive_stb  (drive_stb)
    );

    assign busy_out = (state == ST_SHIFT);

    always_comb begin
        state_n     = state;
        cpol_n      = cpol_q;
        cpha_n      = cpha_q;
        lsbfe_n     = lsbfe_q;
        len_n       = len_q;
        tx_n        = tx_q;
        tx_cnt_n    = tx_cnt;
        rx_cnt_n    = rx_cnt;
        rx_shadow_n = rx_shadow;
        rx_data_n   = rx_data_out;
        done_n      = 1'b0;
        serial_n    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start_in && spe_in) begin
                    state_n     = ST_SHIFT;
                    cpol_n      = cpol_in;
                    cpha_n      = cpha_in;
                    lsbfe_n     = lsbfe_in;
                    len_n       = LEN_W'(eff_len(32'(frame_len_in), DATA_WIDTH));
                    tx_n        = tx_data_in;
                    tx_cnt_n    = '0;
                    rx_cnt_n    = '0;
                    rx_shadow_n = '0;
                end
            end
            ST_SHIFT: begin
                if (!spe_in) begin
                    state_n = ST_IDLE;
                end else if (sample_stb) begin
                    rx_shadow_n[bit_idx(lsbfe_q, len_q, rx_cnt)] = serial_in;
                    rx_cnt_n = rx_cnt + LEN_W'(1);
                    if (rx_cnt_n == len_q) begin
                        state_n   = ST_IDLE;
                        done_n    = 1'b1;
                        rx_data_n = rx_shadow_n & ~({DATA_WIDTH{1'b1}} << len_q);
                    end
                end else if (drive_stb && rx_cnt != '0 && rx_cnt < len_q) begin
                    // Gating on rx_cnt keeps the CPHA=1 first leading edge from advancing.
                    tx_cnt_n = tx_cnt + LEN_W'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase

        if (state_n == ST_SHIFT)
            serial_n = tx_n[bit_idx(lsbfe_n, len_n, tx_cnt_n)];
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state       <= ST_IDLE;
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsbfe_q     <= 1'b0;
            len_q       <= '0;
            tx_q        <= '0;
            tx_cnt      <= '0;
            rx_cnt      <= '0;
            rx_shadow   <= '0;
            rx_data_out <= '0;
            done_out    <= 1'b0;
            serial_out  <= 1'b0;
        end else begin
            state       <= state_n;
            cpol_q      <= cpol_n;
            cpha_q      <= cpha_n;
            lsbfe_q     <= lsbfe_n;
            len_q       <= len_n;
            tx_q        <= tx_n;
            tx_cnt      <= tx_cnt_n;
            rx_cnt      <= rx_cnt_n;
            rx_shadow   <= rx_shadow_n;
            rx_data_out <= rx_data_n;
            done_out    <= done_n;
            serial_out  <= serial_n;
        end
    end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine acting as the SCK generator and SPI slave.
module tb_spi_shift_engine;
    import spi_pkg::*;

    localparam int DW = 16;
    localparam int LW = $clog2(DW + 1);

    logic          clk_in = 1'b0;
    logic          rstn_in, spe_in, cpol_in, cpha_in, lsbfe_in, start_in;
    logic [LW-1:0] frame_len_in;
    logic [DW-1:0] tx_data_in, rx_data_out;
    logic          sck_rise_in, sck_fall_in, serial_in, serial_out, busy_out, done_out;
    logic          loop, sin_drv;

    int            vectors = 0;
    int            miscompares = 0;
    logic          exp_q[$];
    logic [DW-1:0] last_rx;

    assign serial_in = loop ? serial_out : sin_drv;

    always #5 clk_in = ~clk_in;

    spi_shift_engine #(.DATA_WIDTH(DW)) dut (
        .clk_in       (clk_in),
        .rstn_in      (rstn_in),
        .spe_in       (spe_in),
        .cpol_in      (cpol_in),
        .cpha_in      (cpha_in),
        .lsbfe_in     (lsbfe_in),
        .frame_len_in (frame_len_in),
        .start_in     (start_in),
        .tx_data_in   (tx_data_in),
        .sck_rise_in  (sck_rise_in),
        .sck_fall_in  (sck_fall_in),
        .serial_in    (serial_in),
        .serial_out   (serial_out),
        .busy_out     (busy_out),
        .done_out     (done_out),
        .rx_data_out  (rx_data_out)
    );

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic r, input logic f);
        sck_rise_in = r;
        sck_fall_in = f;
        step();
        sck_rise_in = 1'b0;
        sck_fall_in = 1'b0;
    endtask

    // abort_kind: 1 = drop spe_in, 2 = assert reset; taken after abort_at samples.
    task automatic frame(input logic [1:0] mode, input logic lsb, input int lenf,
                         input logic [DW-1:0] tx, input logic [DW-1:0] rxpat,
                         input int abort_at, input int abort_kind,
                         input bit pre_started, input bit chain,
                         input bit dbl, input bit mid_start);
        int            len, idx;
        logic          cp, ph, r;
        logic [DW-1:0] rx_exp;
        bit            fin;
        len    = (lenf == 0 || lenf > DW) ? DW : lenf;
        cp     = mode[1];
        ph     = mode[0];
        rx_exp = (loop ? tx : rxpat) & ((len == DW) ? {DW{1'b1}} : DW'((32'h1 << len) - 1));
        exp_q.delete();
        for (int k = 0; k < len; k++) begin
            idx = lsb ? k : len - 1 - k;
            exp_q.push_back(tx[idx]);
        end

        cpol_in      = cp;
        cpha_in      = ph;
        lsbfe_in     = lsb;
        frame_len_in = LW'(lenf);
        tx_data_in   = tx;
        if (!pre_started) start_in = 1'b1;
        step();
        start_in = 1'b0;
        chk1("busy_at_start", busy_out, 1'b1);
        chk1("first_bit", serial_out, exp_q[0]);

        fin = 1'b0;
        for (int k = 0; k < len && !fin; k++) begin
            for (int e = 0; e < 2 && !fin; e++) begin
                step();
                r = (e == 0) ? ~cp : cp;
                if (e == int'(ph)) begin
                    if (dbl) begin
                        pulse(1'b1, 1'b1);
                        chk1("dbl_busy", busy_out, 1'b1);
                        chk1("dbl_hold", serial_out, exp_q[0]);
                    end
                    idx = lsb ? k : len - 1 - k;
                    sin_drv = rxpat[idx];
                    chk1("busy_mid", busy_out, 1'b1);
                    chk1("tx_bit", serial_out, exp_q.pop_front());
                    pulse(r, ~r);
                    if (k == len - 1) begin
                        fin = 1'b1;
                        chk1("done_pulse", done_out, 1'b1);
                        chk1("busy_end", busy_out, 1'b0);
                        chk1("serial_idle", serial_out, 1'b0);
                        chk16("rx_data", rx_data_out, rx_exp);
                        last_rx = rx_exp;
                        if (chain) begin
                            start_in = 1'b1;
                        end else begin
                            step();
                            chk1("done_once", done_out, 1'b0);
                            if (!ph) begin
                                pulse(cp, ~cp);
                                step();
                                chk1("late_trail_busy", busy_out, 1'b0);
                                chk1("late_trail_done", done_out, 1'b0);
                            end
                        end
                    end else if (k + 1 == abort_at) begin
                        fin = 1'b1;
                        if (abort_kind == 1) begin
                            spe_in = 1'b0;
                            step();
                            spe_in = 1'b1;
                            chk1("abort_busy", busy_out, 1'b0);
                            chk1("abort_done", done_out, 1'b0);
                            chk1("abort_serial", serial_out, 1'b0);
                            chk16("abort_rx_keep", rx_data_out, last_rx);
                        end else begin
                            rstn_in = 1'b0;
                            #1;
                            chk1("rst_busy", busy_out, 1'b0);
                            chk1("rst_done", done_out, 1'b0);
                            chk1("rst_serial", serial_out, 1'b0);
                            chk16("rst_rx", rx_data_out, '0);
                            last_rx = '0;
                            step();
                            rstn_in = 1'b1;
                        end
                        for (int i = 0; i < 3; i++) begin
                            pulse(r, ~r);
                            step();
                            chk1("post_abort_done", done_out, 1'b0);
                        end
                        chk1("post_abort_busy", busy_out, 1'b0);
                    end
                end else begin
                    if (mid_start && k == 2) begin
                        start_in     = 1'b1;
                        tx_data_in   = ~tx;
                        cpol_in      = ~cp;
                        cpha_in      = ~ph;
                        lsbfe_in     = ~lsb;
                        frame_len_in = LW'(3);
                        step();
                        start_in = 1'b0;
                    end
                    pulse(r, ~r);
                end
            end
        end
    endtask

    initial begin
        rstn_in = 1'b0; spe_in = 1'b1; cpol_in = 1'b0; cpha_in = 1'b0; lsbfe_in = 1'b0;
        frame_len_in = '0; start_in = 1'b0; tx_data_in = '0; sck_rise_in = 1'b0;
        sck_fall_in = 1'b0; sin_drv = 1'b0; loop = 1'b0; last_rx = '0;
        step();
        step();
        chk1("reset_busy", busy_out, 1'b0);
        chk1("reset_done", done_out, 1'b0);
        chk1("reset_serial", serial_out, 1'b0);
        chk16("reset_rx", rx_data_out, '0);
        rstn_in = 1'b1;
        step();

        // idle strobes and a start without enable do nothing
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        spe_in = 1'b0; start_in = 1'b1; tx_data_in = 16'hFFFF;
        step();
        start_in = 1'b0; spe_in = 1'b1;
        step();
        chk1("idle_busy", busy_out, 1'b0);
        chk1("idle_serial", serial_out, 1'b0);

        // mode 0 loopback, then abort keeps 0xA5, then clean frame
        loop = 1'b1;
        frame(SPI_MODE0, 1'b0, 8, 16'h00A5, 16'h0000, -1, 0, 0, 0, 0, 0);
        loop = 1'b0;
        frame(SPI_MODE0, 1'b0, 8, 16'h005A, 16'h00FF, 3, 1, 0, 0, 0, 0);
        frame(SPI_MODE2, 1'b0, 8, 16'h0081, 16'h007E, -1, 0, 0, 0, 0, 0);

        // mode 3 LSB-first
        frame(SPI_MODE3, 1'b1, 8, 16'h003C, 16'h0096, -1, 0, 0, 0, 0, 0);

        // short, full-width (len 0), oversize and single-bit frames
        frame(SPI_MODE1, 1'b0, 5, 16'h0013, 16'h0019, -1, 0, 0, 0, 0, 0);
        frame(SPI_MODE1, 1'b0, 0, 16'hBEEF, 16'h1234, -1, 0, 0, 0, 0, 0);
        frame(SPI_MODE0, 1'b1, 17, 16'hC3A5, 16'h5AC3, -1, 0, 0, 0, 0, 0);
        frame(SPI_MODE2, 1'b0, 1, 16'hFFFE, 16'hFFFF, -1, 0, 0, 0, 0, 0);

        // mid-frame start ignored, back-to-back start at done, double strobes rejected
        frame(SPI_MODE0, 1'b0, 8, 16'h006D, 16'h0092, -1, 0, 0, 1, 0, 1);
        frame(SPI_MODE1, 1'b1, 8, 16'h00B4, 16'h004B, -1, 0, 1, 0, 1, 0);

        // reset mid-frame, then recovery
        frame(SPI_MODE3, 1'b0, 8, 16'h00E7, 16'h0018, 4, 2, 0, 0, 0, 0);
        frame(SPI_MODE0, 1'b0, 16, 16'h8001, 16'h7FFE, -1, 0, 0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
Name: spi_shift_engine

Overview:
Parametrised, clk-synchronous successor of the SCK-clocked SPI shifter. Runs on the system clock and consumes one-cycle SCK edge strobes from the SCK generator. Supports all four CPOL/CPHA modes, MSB/LSB-first order and a runtime frame length of 1..DATA_WIDTH bits. Provides a start/busy/done handshake toward the SPI register block and full-duplex TX/RX.

Parameters:
DATA_WIDTH, 8, maximum frame length in bits; legal range 4..32.
LEN_W, $clog2(DATA_WIDTH+1), width of frame_len_in and internal counters; derived, never overridden.

Ports:
clk_in  input  1  system clock
rstn_in  input  1  asynchronous, active-low reset
spe_in  input  1  SPI enable; low aborts any frame
cpol_in  input  1  clock polarity, latched at start
cpha_in  input  1  clock phase, latched at start
lsbfe_in  input  1  1 = LSB first, latched at start
frame_len_in  input  LEN_W  bits per frame; 0 or >DATA_WIDTH means DATA_WIDTH; latched at start
start_in  input  1  one-cycle frame request
tx_data_in  input  DATA_WIDTH  frame data, right-aligned, latched at start
sck_rise_in  input  1  one-cycle strobe, SCK rising edge
sck_fall_in  input  1  one-cycle strobe, SCK falling edge
serial_in  input  1  receive line (pre-synchronised)
serial_out  output  1  transmit line
busy_out  output  1  frame in progress
done_out  output  1  one-cycle frame-complete pulse
rx_data_out  output  DATA_WIDTH  last received frame, right-aligned

Behaviour:
- Reset: state IDLE, busy_out=0, done_out=0, serial_out=0, rx_data_out=0, counters 0.
- Edge mapping uses latched cpol and cpha:
  - leading = cpol ? fall : rise; trailing = the other strobe.
  - sample edge = cpha ? trailing : leading; drive edge = cpha ? leading : trailing.
  - rise and fall strobes in the same cycle: both ignored.
- Bit index for count k: idx(k) = lsbfe ? k : len-1-k.
- IDLE:
  - serial_out=0.
  - start_in=1 with spe_in=1 at cycle T: latch config and tx_data_in; tx_cnt=0, rx_cnt=0, rx_shadow=0.
  - At T+1: busy_out=1 and serial_out=tx[idx(0)].
  - Edge strobes in IDLE or in cycle T are ignored.
- SHIFT:
  - serial_out=tx[idx(tx_cnt)], registered.
  - Sample edge: rx_shadow[idx(rx_cnt)] <= serial_in; rx_cnt++.
  - Drive edge: if 0 < rx_cnt < len then tx_cnt++. In CPHA=1 the first leading edge therefore does not advance.
  - start_in is ignored while busy.
  - Configuration input changes have no effect mid-frame.
- Completion: the sample edge making rx_cnt==len at cycle E gives, at E+1:
  - rx_data_out=rx_shadow, with bits [DATA_WIDTH-1:len]=0;
  - done_out=1 for exactly one cycle;
  - busy_out=0, state IDLE, serial_out=0.
  - A new start_in is accepted at E+1, so back-to-back frames are supported.
  - A CPHA=0 trailing strobe after the final sample falls in IDLE and is ignored.
- Abort: spe_in=0 in any cycle gives, next cycle: IDLE, busy_out=0, serial_out=0, no done_out, rx_data_out unchanged.
- rstn_in asserted mid-frame: all outputs go to their reset values immediately.
- Widths: counters are LEN_W bits and never wrap, because the counters stop at len.

Decomposition:
- Package spi_pkg holds:
  - state encoding (ST_IDLE, ST_SHIFT);
  - mode constants SPI_MODE0..3;
  - function eff_len(frame_len, DATA_WIDTH) implementing the 0/oversize rule.
- One sub-module, spi_edge_sel: maps sck_rise_in/sck_fall_in plus latched cpol/cpha to sample_stb/drive_stb, including the simultaneous-strobe rejection.

Test Plan:
1. Mode 0, MSB-first, len=8, tx=0xA5, serial_in looped from serial_out -> serial_out bits 1,0,1,0,0,1,0,1 valid at each sample edge; rx_data_out=0xA5; done_out high for 1 cycle; busy_out high from T+1 to E.
2. Mode 3, LSB-first, len=8, tx=0x3C, serial_in driving 0x96 LSB-first -> serial_out 0,0,1,1,1,1,0,0; rx_data_out=0x96; first leading edge does not advance tx.
3. Mode 1, DATA_WIDTH=16, len=5, MSB-first, tx=0x0013, serial_in driving 1,1,0,0,1 -> serial_out 1,0,0,1,1; rx_data_out=0x0019; then frame_len_in=0 -> 16-bit frame.
4. Abort: spe_in low after 3 sample edges -> busy_out=0 next cycle; no done_out; rx_data_out keeps its previous value (0xA5); a following start runs a clean full frame.
5. start_in pulsed mid-frame and on the done cycle E+1 -> mid-frame pulse ignored; pulse at E+1 starts the next frame with busy_out continuous except at E+1. Simultaneous rise+fall strobes -> no count change.
6. rstn_in asserted mid-frame -> busy_out, done_out, serial_out=0 and rx_data_out=0 immediately; no spurious done_out after release.
